// File: rtl/issue_pkg.sv
// rtl/issue_pkg.sv - shared constants, entry layout and clamp helper for the issue queue
package issue_pkg;

  // Default pc / instruction width
  localparam int XLEN = 32;

  // Entry layout {pc, inst}: pc in the high field, inst in the low field
  localparam int ENTRY_W = 2 * XLEN;
  localparam int PC_LSB  = XLEN;
  localparam int INST_LSB = 0;

  // Clamp helper: smaller of two unsigned quantities
  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/inst_issue_queue_lead_ones_cnt.sv
// rtl/inst_issue_queue_lead_ones_cnt.sv - counts the leading ones of a vector starting at bit 0
module lead_ones_cnt #(
  parameter int W = 2
) (
  input  logic [W-1:0]             i_vec,
  output logic [$clog2(W+1)-1:0]   o_cnt
);

  localparam int CW = $clog2(W + 1);

  logic w_run;

  // Count ones from bit 0 upward; the first zero stops the run
  always_comb begin
    o_cnt = '0;
    w_run = 1'b1;
    for (int i = 0; i < W; i++) begin
      w_run = w_run & i_vec[i];
      if (w_run) o_cnt = o_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/inst_issue_queue.sv
// rtl/inst_issue_queue.sv - circular fetch-to-issue buffer, IN_W lanes in, OUT_W lanes out, flushable
module inst_issue_queue #(
  parameter int DEPTH = 8,
  parameter int IN_W  = 2,
  parameter int OUT_W = 2,
  parameter int XLEN  = issue_pkg::XLEN
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [IN_W-1:0]              in_valid,
  input  logic [IN_W*XLEN-1:0]         in_pc,
  input  logic [IN_W*XLEN-1:0]         in_inst,
  output logic                         in_ready,
  output logic [OUT_W-1:0]             out_valid,
  output logic [OUT_W*XLEN-1:0]        out_pc,
  output logic [OUT_W*XLEN-1:0]        out_inst,
  input  logic [$clog2(OUT_W+1)-1:0]   out_take,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  import issue_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int NW = $clog2(IN_W + 1);
  localparam int EW = 2 * XLEN;

  logic [EW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_in_ready;
  logic [NW-1:0] w_lead;
  logic [NW-1:0] w_n_in;
  logic [CW-1:0] w_n_out;
  logic [PW-1:0] w_widx [IN_W];

  lead_ones_cnt #(.W(IN_W)) u_lead (
    .i_vec (in_valid),
    .o_cnt (w_lead)
  );

  // Space check uses only the current occupancy; a same-cycle dequeue does not help
  assign w_in_ready = (int'(DEPTH) - int'(r_count)) >= IN_W;
  assign w_n_in     = w_in_ready ? w_lead : '0;
  assign w_n_out    = CW'(min_u(int'(out_take), int'(r_count)));

  assign in_ready = w_in_ready;
  assign count    = r_count;

  // Write slots for each lane, wrapping modulo DEPTH (power of two)
  always_comb begin
    for (int i = 0; i < IN_W; i++) begin
      w_widx[i] = r_tail + PW'(i);
    end
  end

  // Storage write; not cleared by reset/flush, only the pointers are
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      for (int i = 0; i < IN_W; i++) begin
        if (NW'(i) < w_n_in) begin
          r_mem[w_widx[i]] <= {in_pc[i*XLEN +: XLEN], in_inst[i*XLEN +: XLEN]};
        end
      end
    end
  end

  // Pointer and occupancy update; reset first, then flush, then normal traffic
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_n_out);
      r_tail  <= r_tail + PW'(w_n_in);
      r_count <= r_count + CW'(w_n_in) - w_n_out;
    end
  end

  // Present the oldest OUT_W entries in order; invalid lanes read as zero
  always_comb begin
    logic [PW-1:0] ridx;
    out_valid = '0;
    out_pc    = '0;
    out_inst  = '0;
    ridx      = '0;
    for (int i = 0; i < OUT_W; i++) begin
      ridx = r_head + PW'(i);
      if (r_count > CW'(i)) begin
        out_valid[i]              = 1'b1;
        out_pc[i*XLEN +: XLEN]    = r_mem[ridx][EW-1:XLEN];
        out_inst[i*XLEN +: XLEN]  = r_mem[ridx][XLEN-1:0];
      end
    end
  end

endmodule

// File: doc/inst_issue_queue.md
# inst_issue_queue

Parametrised fetch-to-issue instruction buffer for the multi-issue MIPS core, placed between the pc/fetch stage and the issue engine/decode registers. It accepts up to IN_W fetched {pc, instruction} pairs per cycle and presents the oldest OUT_W entries in program order. The issue logic consumes 0..OUT_W of them per cycle. This generalises the fixed two-slot master/slave fetch pairing: the issue width becomes a parameter, and fetch and decode are decoupled by a circular buffer. A branch redirect flushes the whole buffer.

## Interface
Parameters:
- DEPTH, 8: entry count; power of two, ≥ max(IN_W, OUT_W)+2
- IN_W, 2: enqueue lanes per cycle
- OUT_W, 2: dequeue lanes per cycle
- XLEN, 32: pc and instruction width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous active-high reset
- flush  in  1  redirect (branch/jump taken); discard every entry
- in_valid  in  IN_W  lane valid; lane 0 is the oldest
- in_pc  in  IN_W*XLEN  lane i at bits [i*XLEN +: XLEN]
- in_inst  in  IN_W*XLEN  same packing as in_pc
- in_ready  out  1  free entries ≥ IN_W
- out_valid  out  OUT_W  lane i valid when count > i
- out_pc  out  OUT_W*XLEN  pc of entry head+i
- out_inst  out  OUT_W*XLEN  instruction of entry head+i; 0 when lane invalid
- out_take  in  $clog2(OUT_W+1)  number of entries consumed this cycle
- count  out  $clog2(DEPTH+1)  current occupancy

## Operation
- Storage is a circular buffer of DEPTH entries {pc, inst}, with head/tail pointers of $clog2(DEPTH) bits and wrap modulo DEPTH, plus an explicit occupancy count.
- Enqueue count n_in:
  - n_in is the number of leading ones of in_valid; lanes after the first 0 are ignored.
  - n_in is forced to 0 when in_ready=0.
  - Accepted lanes are written at tail, tail+1, … in lane order.
- Dequeue count n_out = min(out_take, count). An out_take larger than the valid lane count is clamped; the excess is not an error.
- Outputs are purely combinational from storage and head. out_valid is thermometer-coded. Invalid lanes drive 0 on out_pc and out_inst.
- Next state: count' = count + n_in − n_out, tail' = tail + n_in, head' = head + n_out.
- in_ready is computed from current count only: in_ready = (DEPTH − count ≥ IN_W). A same-cycle dequeue does not raise it.
- Priority order is rst, then flush, then normal operation.
  - flush and rst both set head=tail=count=0.
  - Same-cycle enqueue and out_take are discarded.
  - Storage contents are not cleared.
- Simultaneous enqueue and dequeue are allowed at every occupancy, including the full boundary. Because in_ready already guarantees space, no same-cycle bypass is needed.
- The queue never overflows by construction. Underflow is prevented by the clamp.

## Timing
- Reset values: count=0, out_valid=0, out_pc=0, out_inst=0, in_ready=1.
- Latency: an entry enqueued at edge k is visible on out_* after edge k (combinationally in cycle k+1). There is no fall-through path from in_* to out_*.
- Dequeue takes effect at the edge; the next-oldest entries appear on lane 0 in the following cycle.
- After flush asserts at edge k, out_valid=0 and in_ready=1 in cycle k+1.
- Wrap-around is seamless: entries spanning index DEPTH−1 → 0 keep program order on the out lanes.
- Mid-operation rst behaves exactly like flush.

## Structure
- Shared package/header issue_pkg holds:
  - XLEN
  - entry layout macros (ENTRY_W = 2*XLEN, pc field high, inst field low)
  - the clamp/min helper function
- One sub-module, lead_ones_cnt (parametrised width), counts the leading ones of in_valid. It is reused later by the issue engine.
- Storage is a reg array with read indices head+i; write indices tail+i are computed with modulo-DEPTH masking.

## Test plan
- Reset then fill: rst 1 cycle, then in_valid=2'b11 every cycle (DEPTH=8) → count 2,4,6,8; in_ready drops to 0 when count=7 or 8 (at count=6 it stays 1); no 9th entry accepted.
- In-order drain with wrap: enqueue pcs 0x00..0x1C, take 2 per cycle while enqueuing 2 per cycle for 6 cycles → out_pc pairs strictly ascending by 4 across the index 7→0 boundary.
- Partial and illegal lanes: in_valid=2'b10 → n_in=0, count unchanged; in_valid=2'b01 → count+1.
- Clamp: count=1, out_take=2 → count=0 next cycle; out_valid=0; no pointer corruption (next enqueued pc appears on lane 0).
- Flush with traffic: count=5 with flush=1, in_valid=2'b11 and out_take=2 in the same cycle → next cycle count=0, out_valid=0, in_ready=1; the enqueued pair is lost.
- Mid-run reset: rst asserted at count=6 → identical to flush; resumes correctly on the next enqueue.
